pc_unit: RTL and testbench
==========================

# pc_unit

Program-counter unit for the RISC-V core's fetch stage. Holds the architectural PC in a register and computes the next-PC combinationally from that PC and a next-PC select code from the control unit. The fetch address is the registered PC. The next-PC value is loaded when the control unit asserts the write enable. It is used in both the multi-cycle datapath (where PC writes are gated) and the pipelined datapath.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded by reset.
- TRAP_VEC, 32'h0000_0100, target selected by next-PC select code 2'b11.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, synchronous and active-high.
- PCwr  in  1  PC write enable; PC loads the next-PC value on a clock edge only when high.
- NPCop  in  2  next-PC select.
- Imm32  in  32  sign-extended, already-scaled branch/jump offset.
- Rs1  in  32  register operand for the JALR target.
- PCout  out  32  current PC (registered); this is the fetch address.
- NPCout  out  32  next-PC value (combinational).
- PCplus4  out  32  PCout+4; this is the link value for JAL/JALR.

## Operation
- NPCop decode:
  - 2'b00: NPCout = PCout + 4 (sequential).
  - 2'b01: NPCout = PCout + Imm32 (taken branch / JAL).
  - 2'b10: NPCout = (Rs1 + Imm32) & ~32'h1 (JALR).
  - 2'b11: NPCout = TRAP_VEC.
- Arithmetic rules:
  - All adds are 32-bit modulo 2^32. Overflow wraps silently; no flag is produced.
  - Imm32 is used as given; the unit does no sign extension or shifting.
- While rst is high, NPCout = RESET_PC regardless of NPCop.
- PC register update on each rising edge:
  - rst=1: PCout <= RESET_PC. Reset has priority over PCwr.
  - rst=0, PCwr=1: PCout <= NPCout.
  - rst=0, PCwr=0: PCout holds.
- PCplus4 = PCout + 4 at all times. It is independent of NPCop and rst.
- No alignment checking. Bit 1 of a target may be 1. Bit 0 is forced to 0 only for JALR.

## Timing
- NPCout and PCplus4 are purely combinational from PCout, NPCop, Imm32, Rs1 and rst. There are no combinational paths from any input to PCout.
- PCout has a latency of one clock from PCwr/NPCop to the new value.
- PCout reset value is RESET_PC, visible after the first rising edge with rst=1. Before the first reset edge, PCout is undefined.
- Reset mid-operation: on the edge where rst=1, PCout is forced to RESET_PC even if PCwr=1 with a different NPCout.
- NPCop changes while PCwr=0 affect only NPCout. PCout is unchanged.
- Holding PCwr=1 across N edges with NPCop=00 advances PCout by 4·N.

## Structure
- A shared core package holds:
  - the NPCop encodings as named constants: NPC_SEQ=2'b00, NPC_BR=2'b01, NPC_JALR=2'b10, NPC_TRAP=2'b11;
  - the XLEN=32 constant.
- The unit has one sub-module, npc_logic, which is the combinational next-PC mux and adders.
- The top level, pc_unit, contains the PC register and instantiates npc_logic.
- The reset-value selection lives in the top level. npc_logic receives rst as its Reset input.

## Test plan
- Reset and hold:
  - rst=1 for 1 edge → PCout=0x00000000, NPCout=0x00000000 while rst is high.
  - rst=0, PCwr=0, NPCop=00 → PCout stays 0 over 3 edges; NPCout=0x00000004.
- Sequential:
  - From PC=0, PCwr=1, NPCop=00 for 2 edges → PCout=0x00000004, then 0x00000008.
  - PCplus4 tracks PCout: 0x00000008, then 0x0000000C.
- Branch:
  - At PC=0x00000008, NPCop=01, Imm32=0x00123400 → NPCout=0x00123408 immediately.
  - With PCwr=0, PCout still reads 0x00000008. After PCwr=1 and one edge, PCout=0x00123408.
- JALR and trap:
  - Rs1=0x10100101, Imm32=0x00123400, NPCop=10 → NPCout=0x10223500 (bit 0 cleared). After PCwr=1 and one edge, PCout=0x10223500.
  - NPCop=11 → PCout=0x00000100 after one edge.
- Wrap and reset priority:
  - At PC=0xFFFFFFFC, NPCop=00, PCwr=1 → PCout=0x00000000 after one edge.
  - Next edge with rst=1, PCwr=1, NPCop=01, Imm32=0x40 → PCout=RESET_PC (0x00000000), not 0x40.

Source files
------------

// File: rtl/pc_unit_pkg.sv
// pc_unit_pkg: shared core constants for the fetch-stage PC unit
package pc_unit_pkg;
  localparam int XLEN = 32;
  localparam logic [1:0] NPC_SEQ  = 2'b00;
  localparam logic [1:0] NPC_BR   = 2'b01;
  localparam logic [1:0] NPC_JALR = 2'b10;
  localparam logic [1:0] NPC_TRAP = 2'b11;
endpackage

// File: rtl/pc_unit_if.sv
// pc_unit_if: control-unit to PC-unit bus; master is the control side
import pc_unit_pkg::*;
interface pc_unit_if;
  logic            PCwr;
  logic [1:0]      NPCop;
  logic [XLEN-1:0] Imm32;
  logic [XLEN-1:0] Rs1;
  logic [XLEN-1:0] PCout;
  logic [XLEN-1:0] NPCout;
  logic [XLEN-1:0] PCplus4;
  modport master (output PCwr, NPCop, Imm32, Rs1, input PCout, NPCout, PCplus4);
  modport slave  (input PCwr, NPCop, Imm32, Rs1, output PCout, NPCout, PCplus4);
endinterface

// File: rtl/pc_unit_npc_logic.sv
// npc_logic: combinational next-PC mux and adders
import pc_unit_pkg::*;
module npc_logic #(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic            Reset,
  input  logic [XLEN-1:0] i_pc,
  input  logic [1:0]      i_npcop,
  input  logic [XLEN-1:0] i_imm,
  input  logic [XLEN-1:0] i_rs1,
  output logic [XLEN-1:0] o_npc,
  output logic [XLEN-1:0] o_pcplus4
);
  logic [XLEN-1:0] w_br, w_jalr;
  always_comb begin
    o_pcplus4 = i_pc + 32'd4;
    w_br      = i_pc + i_imm;
    w_jalr    = (i_rs1 + i_imm) & ~32'h1;
    o_npc     = Reset                ? RESET_PC  :
                i_npcop == NPC_SEQ  ? o_pcplus4 :
                i_npcop == NPC_BR   ? w_br      :
                i_npcop == NPC_JALR ? w_jalr    : TRAP_VEC;
  end
endmodule

// File: rtl/pc_unit.sv
// pc_unit: architectural PC register with next-PC selection for fetch
import pc_unit_pkg::*;
module pc_unit #(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VEC = 32'h0000_0100
) (
  input logic     clk,
  input logic     rst,
  pc_unit_if.slave bus
);
  logic [XLEN-1:0] r_pc, w_npc, w_pcplus4;
  // reset value is owned here and handed down so NPCout matches PCout's reset target
  npc_logic #(.RESET_PC(RESET_PC), .TRAP_VEC(TRAP_VEC)) u_npc (
    .Reset     (rst),
    .i_pc      (r_pc),
    .i_npcop   (bus.NPCop),
    .i_imm     (bus.Imm32),
    .i_rs1     (bus.Rs1),
    .o_npc     (w_npc),
    .o_pcplus4 (w_pcplus4)
  );
  always_ff @(posedge clk)
    if (rst) r_pc <= RESET_PC;
    else if (bus.PCwr) r_pc <= w_npc;
  assign bus.PCout   = r_pc;
  assign bus.NPCout  = w_npc;
  assign bus.PCplus4 = w_pcplus4;
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed plan plus randomized run against a reference PC model
module tb_pc_unit;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] TRAP   = 32'h0000_0100;
  logic clk = 1'b0;
  logic rst;
  int errors = 0;
  int checks = 0;
  logic [31:0] m_pc, m_npc;
  pc_unit_if bus ();
  pc_unit #(.RESET_PC(RST_PC), .TRAP_VEC(TRAP)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] ref_npc(input logic r, input logic [1:0] op,
      input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] rs1);
    logic [32:0] s;
    if (r) return RST_PC;
    case (op)
      2'd0: s = {1'b0, pc} + 33'd4;
      2'd1: s = {1'b0, pc} + {1'b0, imm};
      2'd2: s = ({1'b0, rs1} + {1'b0, imm}) & ~33'h1;
      default: s = {1'b0, TRAP};
    endcase
    return s[31:0];
  endfunction
  initial begin
    rst = 1'b1; bus.PCwr = 1'b0; bus.NPCop = 2'b00; bus.Imm32 = '0; bus.Rs1 = '0;
    tick();
    chk("reset_pc", bus.PCout, 32'h0);
    chk("reset_npc", bus.NPCout, 32'h0);
    bus.NPCop = 2'b11;
    #1 chk("reset_npc_trapop", bus.NPCout, 32'h0);
    rst = 1'b0; bus.NPCop = 2'b00;
    #1 chk("hold_npc", bus.NPCout, 32'h4);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_pc", bus.PCout, 32'h0);
    end
    bus.PCwr = 1'b1;
    tick();
    chk("seq_pc1", bus.PCout, 32'h4);
    chk("seq_plus4_1", bus.PCplus4, 32'h8);
    tick();
    chk("seq_pc2", bus.PCout, 32'h8);
    chk("seq_plus4_2", bus.PCplus4, 32'hC);
    bus.PCwr = 1'b0; bus.NPCop = 2'b01; bus.Imm32 = 32'h0012_3400;
    #1 chk("br_npc", bus.NPCout, 32'h0012_3408);
    tick();
    chk("br_hold_pc", bus.PCout, 32'h8);
    bus.PCwr = 1'b1;
    tick();
    chk("br_pc", bus.PCout, 32'h0012_3408);
    bus.NPCop = 2'b10; bus.Rs1 = 32'h1010_0101;
    #1 chk("jalr_npc", bus.NPCout, 32'h1022_3500);
    tick();
    chk("jalr_pc", bus.PCout, 32'h1022_3500);
    bus.NPCop = 2'b11;
    tick();
    chk("trap_pc", bus.PCout, 32'h100);
    bus.NPCop = 2'b10; bus.Rs1 = 32'hFFFF_FFFC; bus.Imm32 = 32'h0;
    tick();
    chk("to_top_pc", bus.PCout, 32'hFFFF_FFFC);
    bus.NPCop = 2'b00;
    #1 chk("wrap_plus4", bus.PCplus4, 32'h0);
    tick();
    chk("wrap_pc", bus.PCout, 32'h0);
    rst = 1'b1; bus.NPCop = 2'b01; bus.Imm32 = 32'h40;
    #1 chk("rstprio_npc", bus.NPCout, RST_PC);
    tick();
    chk("rstprio_pc", bus.PCout, RST_PC);
    m_pc = RST_PC;
    for (int i = 0; i < 300; i++) begin
      rst = ($urandom_range(0, 19) == 0);
      bus.PCwr = $urandom_range(0, 1);
      bus.NPCop = 2'($urandom_range(0, 3));
      bus.Imm32 = $urandom;
      bus.Rs1 = $urandom;
      #1;
      m_npc = ref_npc(rst, bus.NPCop, m_pc, bus.Imm32, bus.Rs1);
      chk("rnd_npc", bus.NPCout, m_npc);
      chk("rnd_plus4", bus.PCplus4, m_pc + 32'd4);
      tick();
      if (rst) m_pc = RST_PC;
      else if (bus.PCwr) m_pc = m_npc;
      chk("rnd_pc", bus.PCout, m_pc);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
